// File: rtl/neuron_mac_seq.sv
// rtl/neuron_mac_seq.sv - sequential MAC neuron: one multiply-accumulate per clock, round, saturate, optional ReLU
// Inputs are unsigned Q1.FRAC, weights/bias/result signed Q1.FRAC; weights and bias come from an external ROM.
module neuron_mac_seq #(
   parameter int N_IN   = 4,
   parameter int W      = 16,
   parameter int FRAC   = 15,
   parameter int ADDR_W = 3,
   parameter int RELU   = 1,
   localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N_IN*W-1:0]   in_vec,
   input  logic [ADDR_W-1:0]   addr,
   output logic [ADDR_W-1:0]   rom_row,
   output logic [IDX_W-1:0]    rom_idx,
   input  logic [W-1:0]        rom_w,
   input  logic [W-1:0]        rom_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        out_data,
   output logic                out_sat
);

   localparam int ACC_W = 2*W + 1 + $clog2(N_IN + 1);
   localparam logic [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_FIN, S_HOLD} state_t;

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [N_IN*W-1:0]        vec_q, vec_d;
   logic                     out_valid_q, out_valid_d;
   logic [W-1:0]             out_data_q, out_data_d;
   logic                     out_sat_q, out_sat_d;

   logic                     last_idx;
   logic [W-1:0]             x_cur;
   logic signed [2*W:0]      x_ext, w_ext, prod;
   logic signed [ACC_W-1:0]  prod_ext, bias_ext, rnd, shifted;
   logic [W-1:0]             clipped, result;
   logic                     clip_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         idx_q       <= '0;
         addr_q      <= '0;
         vec_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         vec_q       <= vec_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign last_idx = (idx_q == IDX_W'(N_IN - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_MAC;
         S_MAC:   if (last_idx) state_d = S_FIN;
         S_FIN:   state_d = S_HOLD;
         S_HOLD:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Input is zero-extended so full-scale unsigned codes multiply as positive values.
   always_comb begin
      x_cur    = vec_q[idx_q*W +: W];
      x_ext    = {{(W+1){1'b0}}, x_cur};
      w_ext    = {{(W+1){rom_w[W-1]}}, rom_w};
      prod     = x_ext * w_ext;
      prod_ext = {{(ACC_W-2*W-1){prod[2*W]}}, prod};
      bias_ext = {{(ACC_W-W){rom_b[W-1]}}, rom_b} << FRAC;
      rnd      = acc_q + HALF;
      shifted  = rnd >>> FRAC;
      clip_sat = 1'b0;
      clipped  = shifted[W-1:0];
      if (shifted > MAX_V) begin
         clipped  = MAX_V[W-1:0];
         clip_sat = 1'b1;
      end else if (shifted < MIN_V) begin
         clipped  = MIN_V[W-1:0];
         clip_sat = 1'b1;
      end
      result = ((RELU != 0) && clipped[W-1]) ? '0 : clipped;
   end

   always_comb begin
      acc_d       = acc_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      vec_d       = vec_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      case (state_q)
         S_IDLE: if (in_valid) begin
            vec_d  = in_vec;
            addr_d = addr;
            acc_d  = bias_ext;
            idx_d  = '0;
         end
         S_MAC: begin
            acc_d = acc_q + prod_ext;
            if (!last_idx) idx_d = idx_q + IDX_W'(1);
         end
         S_FIN: begin
            out_data_d  = result;
            out_sat_d   = clip_sat;
            out_valid_d = 1'b1;
         end
         S_HOLD: if (out_ready) out_valid_d = 1'b0;
         default: ;
      endcase
   end

   // In IDLE the ROM is addressed straight from addr so the bias is available at accept.
   always_comb begin
      in_ready = (state_q == S_IDLE);
      rom_row  = (state_q == S_IDLE) ? addr : addr_q;
      rom_idx  = (state_q == S_IDLE) ? '0 : idx_q;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb/tb_neuron_mac_seq.sv - self-checking bench for neuron_mac_seq (ReLU and linear instances)
module tb_neuron_mac_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_vec;
   logic [2:0]  addr;
   logic        out_ready;

   logic        in_ready1, out_valid1, out_sat1;
   logic [2:0]  rom_row1;
   logic [1:0]  rom_idx1;
   logic [15:0] rom_w1, rom_b1, out_data1;
   logic        in_ready0, out_valid0, out_sat0;
   logic [2:0]  rom_row0;
   logic [1:0]  rom_idx0;
   logic [15:0] rom_w0, rom_b0, out_data0;

   logic [15:0] w_mem [0:7][0:3];
   logic [15:0] b_mem [0:7];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   assign rom_w1 = w_mem[rom_row1][rom_idx1];
   assign rom_b1 = b_mem[rom_row1];
   assign rom_w0 = w_mem[rom_row0][rom_idx0];
   assign rom_b0 = b_mem[rom_row0];

   neuron_mac_seq #(.N_IN(4), .W(16), .FRAC(15), .ADDR_W(3), .RELU(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_vec(in_vec), .addr(addr), .rom_row(rom_row1), .rom_idx(rom_idx1),
      .rom_w(rom_w1), .rom_b(rom_b1), .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .out_sat(out_sat1)
   );

   neuron_mac_seq #(.N_IN(4), .W(16), .FRAC(15), .ADDR_W(3), .RELU(0)) dut_lin (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_vec(in_vec), .addr(addr), .rom_row(rom_row0), .rom_idx(rom_idx0),
      .rom_w(rom_w0), .rom_b(rom_b0), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_sat(out_sat0)
   );

   // Real-valued neuron: dot product in integer Q-units, floor((acc + half) / 2^15), clip, ReLU.
   function automatic void model(input logic [63:0] vec, input logic [2:0] a, input bit relu,
                                 output logic [15:0] d, output logic s);
      longint acc;
      longint r;
      acc = longint'($signed(b_mem[a])) * 32768;
      for (int i = 0; i < 4; i++)
         acc += longint'(vec[i*16 +: 16]) * longint'($signed(w_mem[a][i]));
      r = acc + 16384;
      r = (r >= 0) ? (r / 32768) : -((-r + 32767) / 32768);
      s = 1'b0;
      if (r > 32767) begin r = 32767; s = 1'b1; end
      else if (r < -32768) begin r = -32768; s = 1'b1; end
      if (relu && r < 0) r = 0;
      d = r[15:0];
   endfunction

   task automatic set_row(input logic [2:0] a, input logic [15:0] w, input logic [15:0] b);
      for (int i = 0; i < 4; i++) w_mem[a][i] = w;
      b_mem[a] = b;
   endtask

   // Drives one vector from IDLE with out_ready high and reports what both instances produced.
   task automatic do_txn(input logic [63:0] vec, input logic [2:0] a, output int lat,
                         output logic [15:0] d1, output logic s1,
                         output logic [15:0] d0, output logic s0,
                         output logic v_after, output logic rdy_after);
      in_vec = vec; addr = a; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
      d1 = out_data1; s1 = out_sat1; d0 = out_data0; s0 = out_sat0;
      @(posedge clk); @(negedge clk);
      v_after = out_valid1; rdy_after = in_ready1;
   endtask

   task automatic test_reset;
      n_checks++; if (in_ready1 !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready1); else n_pass++;
      n_checks++; if (out_valid1 !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid1); else n_pass++;
      n_checks++; if (out_data1 !== 16'h0) $display("FAIL reset_out_data got %h exp 0000", out_data1); else n_pass++;
      n_checks++; if (out_sat1 !== 1'b0) $display("FAIL reset_out_sat got %b exp 0", out_sat1); else n_pass++;
      n_checks++; if (out_valid0 !== 1'b0) $display("FAIL reset_lin_out_valid got %b exp 0", out_valid0); else n_pass++;
   endtask

   task automatic test_nominal;
      int lat; logic [15:0] d1, d0; logic s1, s0, va, ra;
      set_row(3'd1, 16'h2000, 16'h1000);
      do_txn({4{16'h4000}}, 3'd1, lat, d1, s1, d0, s0, va, ra);
      n_checks++; if (lat !== 5) $display("FAIL nominal_latency got %0d exp 5", lat); else n_pass++;
      n_checks++; if (d1 !== 16'h5000) $display("FAIL nominal_data got %h exp 5000", d1); else n_pass++;
      n_checks++; if (s1 !== 1'b0) $display("FAIL nominal_sat got %b exp 0", s1); else n_pass++;
      n_checks++; if (d0 !== 16'h5000) $display("FAIL nominal_lin_data got %h exp 5000", d0); else n_pass++;
      n_checks++; if (va !== 1'b0) $display("FAIL nominal_valid_one_cycle got %b exp 0", va); else n_pass++;
      n_checks++; if (ra !== 1'b1) $display("FAIL nominal_ready_return got %b exp 1", ra); else n_pass++;
   endtask

   task automatic test_pos_sat;
      int lat; logic [15:0] d1, d0; logic s1, s0, va, ra;
      set_row(3'd2, 16'h4000, 16'h0000);
      do_txn({4{16'h4000}}, 3'd2, lat, d1, s1, d0, s0, va, ra);
      n_checks++; if (d1 !== 16'h7FFF) $display("FAIL possat_data got %h exp 7fff", d1); else n_pass++;
      n_checks++; if (s1 !== 1'b1) $display("FAIL possat_sat got %b exp 1", s1); else n_pass++;
      n_checks++; if (d0 !== 16'h7FFF || s0 !== 1'b1) $display("FAIL possat_lin got %h/%b exp 7fff/1", d0, s0); else n_pass++;
   endtask

   task automatic test_neg_relu;
      int lat; logic [15:0] d1, d0; logic s1, s0, va, ra;
      set_row(3'd3, 16'hC000, 16'h0000);
      do_txn({4{16'h4000}}, 3'd3, lat, d1, s1, d0, s0, va, ra);
      n_checks++; if (d1 !== 16'h0000) $display("FAIL neg_relu_data got %h exp 0000", d1); else n_pass++;
      n_checks++; if (s1 !== 1'b0) $display("FAIL neg_relu_sat got %b exp 0", s1); else n_pass++;
      n_checks++; if (d0 !== 16'h8000) $display("FAIL neg_linear_data got %h exp 8000", d0); else n_pass++;
      n_checks++; if (s0 !== 1'b0) $display("FAIL neg_linear_sat got %b exp 0", s0); else n_pass++;
   endtask

   task automatic test_unsigned_round;
      int lat; logic [15:0] d1, d0; logic s1, s0, va, ra;
      set_row(3'd4, 16'h0000, 16'h0000);
      w_mem[4][0] = 16'h2000;
      do_txn({48'h0, 16'h8000}, 3'd4, lat, d1, s1, d0, s0, va, ra);
      n_checks++; if (d1 !== 16'h2000) $display("FAIL unsigned_input got %h exp 2000", d1); else n_pass++;
      set_row(3'd5, 16'h0000, 16'h0000);
      w_mem[5][0] = 16'h4000;
      do_txn({48'h0, 16'h0001}, 3'd5, lat, d1, s1, d0, s0, va, ra);
      n_checks++; if (d1 !== 16'h0001) $display("FAIL round_half_up got %h exp 0001", d1); else n_pass++;
   endtask

   task automatic test_random;
      int lat; logic [15:0] d1, d0, m1, m0; logic s1, s0, ms1, ms0, va, ra;
      logic [63:0] vec; logic [2:0] a; logic signed [15:0] t;
      for (int it = 0; it < 16; it++) begin
         a = 3'($urandom_range(0, 7));
         for (int i = 0; i < 4; i++) begin
            t = 16'($urandom);
            if (it % 2 == 1) t = t >>> 3;
            w_mem[a][i] = t;
         end
         b_mem[a] = 16'($urandom);
         vec = {32'($urandom), 32'($urandom)};
         model(vec, a, 1'b1, m1, ms1);
         model(vec, a, 1'b0, m0, ms0);
         do_txn(vec, a, lat, d1, s1, d0, s0, va, ra);
         n_checks++; if (lat !== 5) $display("FAIL rand%0d_latency got %0d exp 5", it, lat); else n_pass++;
         n_checks++; if (d1 !== m1 || s1 !== ms1) $display("FAIL rand%0d_relu got %h/%b exp %h/%b", it, d1, s1, m1, ms1); else n_pass++;
         n_checks++; if (d0 !== m0 || s0 !== ms0) $display("FAIL rand%0d_linear got %h/%b exp %h/%b", it, d0, s0, m0, ms0); else n_pass++;
         n_checks++; if (va !== 1'b0 || ra !== 1'b1) $display("FAIL rand%0d_handoff got %b/%b exp 0/1", it, va, ra); else n_pass++;
      end
   endtask

   task automatic test_backpressure;
      logic [63:0] vec; logic [15:0] m1; logic ms1; int cyc;
      set_row(3'd6, 16'h1800, 16'hF000);
      vec = {16'h7000, 16'h1234, 16'hFFFF, 16'h0800};
      model(vec, 3'd6, 1'b1, m1, ms1);
      out_ready = 1'b0;
      in_vec = vec; addr = 3'd6; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid1 && cyc < 20) begin
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      n_checks++; if (out_data1 !== m1 || out_valid1 !== 1'b1) $display("FAIL bp_result got %h/%b exp %h/1", out_data1, out_valid1, m1); else n_pass++;
      for (int i = 0; i < 10; i++) begin
         in_vec = {32'($urandom), 32'($urandom)}; addr = 3'($urandom_range(0, 7)); in_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         n_checks++;
         if (out_valid1 !== 1'b1 || out_data1 !== m1 || out_sat1 !== ms1 || in_ready1 !== 1'b0)
            $display("FAIL bp_hold%0d got v=%b d=%h s=%b r=%b exp v=1 d=%h s=%b r=0", i, out_valid1, out_data1, out_sat1, in_ready1, m1, ms1);
         else n_pass++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      n_checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) $display("FAIL bp_release got v=%b r=%b exp 0/1", out_valid1, in_ready1); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         n_checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) $display("FAIL bp_no_accept%0d got v=%b r=%b exp 0/1", i, out_valid1, in_ready1); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_mac;
      int lat; logic [15:0] d1, d0, m1, m0; logic s1, s0, ms1, ms0, va, ra; logic [63:0] vec;
      set_row(3'd7, 16'h7FFF, 16'h7FFF);
      in_vec = {4{16'hFFFF}}; addr = 3'd7; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) $display("FAIL rstmac_async got v=%b r=%b exp 0/1", out_valid1, in_ready1); else n_pass++;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); @(negedge clk);
         n_checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) $display("FAIL rstmac_idle%0d got v=%b r=%b exp 0/1", i, out_valid1, in_ready1); else n_pass++;
      end
      set_row(3'd0, 16'hE000, 16'h0400);
      vec = {16'h1000, 16'h2000, 16'h0100, 16'h0010};
      model(vec, 3'd0, 1'b1, m1, ms1);
      model(vec, 3'd0, 1'b0, m0, ms0);
      do_txn(vec, 3'd0, lat, d1, s1, d0, s0, va, ra);
      n_checks++; if (lat !== 5) $display("FAIL rstmac_next_latency got %0d exp 5", lat); else n_pass++;
      n_checks++; if (d1 !== m1 || s1 !== ms1) $display("FAIL rstmac_next_relu got %h/%b exp %h/%b", d1, s1, m1, ms1); else n_pass++;
      n_checks++; if (d0 !== m0 || s0 !== ms0) $display("FAIL rstmac_next_linear got %h/%b exp %h/%b", d0, s0, m0, ms0); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; addr = '0; out_ready = 1'b1;
      for (int r = 0; r < 8; r++) set_row(3'(r), 16'h0000, 16'h0000);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_nominal();
      test_pos_sat();
      test_neg_relu();
      test_unsigned_round();
      test_random();
      test_backpressure();
      test_reset_mid_mac();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequential, parametrised hidden-layer neuron for the MLP classifier: accepts one input vector over a valid/ready handshake, evaluates `sum(x_i * w_i) + b` with one multiply-accumulate per clock, then rounds, saturates and optionally applies ReLU. It sits between the normalised sensor-feature stage and the output layer. It reads its weights and bias from the existing per-neuron ROM (addressed by neuron index) and fixes the unsigned-input handling.

## Interface
- `N_IN`, default 4: inputs per neuron; must be ≥ 1.
- `W`, default 16: data, weight and bias width.
- `FRAC`, default 15: fractional bits; must be ≥ 1. Inputs are unsigned Q1.FRAC; weights, bias and output are signed Q1.FRAC.
- `ADDR_W`, default 3: neuron-index (ROM row) width.
- `RELU`, default 1: 1 applies ReLU; 0 gives a linear output.
- `clk`  in  1  single clock. Reset is asynchronous and active-low (`rst_n`); polarity and synchronicity are fixed.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  high only in IDLE.
- `in_vec`  in  N_IN*W  unsigned inputs; element i is `in_vec[i*W +: W]`.
- `addr`  in  ADDR_W  neuron index, sampled on accept.
- `rom_row`  out  ADDR_W  ROM row: equals `addr` in IDLE, otherwise the latched `addr_q`.
- `rom_idx`  out  clog2(N_IN), minimum 1  weight index within the row.
- `rom_w`  in  W  signed weight, combinational read of (`rom_row`, `rom_idx`).
- `rom_b`  in  W  signed bias, combinational read of `rom_row`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  W  signed Q1.FRAC result.
- `out_sat`  out  1  result was clipped by saturation; evaluated before ReLU.

## Operation
- **States:** IDLE, MAC, FIN, HOLD.
- **IDLE:**
  - An accept happens when `in_valid && in_ready`.
  - On accept, latch `in_vec` and `addr`, load `acc <= sext(rom_b) <<< FRAC`, clear `idx`, and go to MAC.
  - While in IDLE, `rom_idx` = 0 and `rom_row` = `addr`, so the bias is read in the same cycle as the accept.
- **MAC:**
  - Each cycle: `acc <= acc + zext(x[idx]) * rom_w`, with `rom_idx = idx`.
  - Inputs are zero-extended to W+1 bits before the signed multiply, so 0x8000 means +1.0, never −1.0.
  - When `idx == N_IN-1`, go to FIN; otherwise increment `idx`.
- **Accumulator width:** ACC_W = 2W+1+clog2(N_IN+1). No internal overflow is possible.
- **FIN:**
  - `r = (acc + 2^(FRAC-1)) >>> FRAC` (round half toward +inf).
  - Clip r to [−2^(W−1), 2^(W−1)−1]; `out_sat` = 1 if clipping occurred.
  - If RELU = 1 and the clipped value is negative, the output is 0.
  - Register `out_data` and `out_sat`, set `out_valid` = 1, and go to HOLD.
- **HOLD:**
  - `out_data`, `out_sat` and `out_valid` stay stable until `out_ready` is sampled high.
  - Then `out_valid` <= 0 and the state returns to IDLE.
  - `in_valid` is ignored in every state except IDLE.
- **Reset (asynchronous, any state, including mid-MAC):**
  - State goes to IDLE; `acc`, `idx`, `addr_q` and the latched inputs clear to 0.
  - `out_valid` = 0, `out_data` = 0, `out_sat` = 0.
  - `in_ready` = 1 after reset.
  - No partial result is ever emitted.

## Timing
- The accept is at clock edge E0. MAC updates occur at edges E1..E(N_IN). FIN registers the result at edge E(N_IN+1), so `out_valid` rises after E(N_IN+1).
  - Latency from accept to `out_valid` is N_IN+1 cycles.
- If `out_ready` is already high when `out_valid` rises, `out_valid` is high for exactly one cycle, and `in_ready` returns high one cycle after that.
- Minimum spacing between accepts is N_IN+3 cycles.
- `in_ready` is a decode of the state register: no combinational path from `in_valid` or `out_ready`.
- `rom_row` and `rom_idx` have a combinational path from `addr` while in IDLE only.

## Test plan
All scenarios use N_IN=4, W=16, FRAC=15, RELU=1 unless stated otherwise.
- **Nominal:** inputs all 0x4000, weights all 0x2000, bias 0x1000 -> `out_data` = 0x5000, `out_sat` = 0, `out_valid` exactly 5 cycles after accept.
- **Positive saturation:** inputs all 0x4000, weights all 0x4000, bias 0 -> `out_data` = 0x7FFF, `out_sat` = 1.
- **Negative result, ReLU on/off:** inputs all 0x4000, weights all 0xC000, bias 0.
  - RELU=1 -> `out_data` = 0x0000, `out_sat` = 0.
  - RELU=0 -> `out_data` = 0x8000, `out_sat` = 0.
- **Unsigned input and rounding:** x0 = 0x8000, w0 = 0x2000, all other inputs and weights 0, bias 0 -> `out_data` = 0x2000.
  - Separately, x0 = 0x0001, w0 = 0x4000 -> `out_data` = 0x0001 (the half rounds up).
- **Backpressure:** hold `out_ready` = 0 for 10 cycles and pulse `in_valid` with new data meanwhile -> `out_data` stable, `in_ready` = 0, new data not accepted. Release `out_ready` -> one transfer, then `in_ready` = 1.
- **Reset mid-MAC:** assert `rst_n` = 0 at the 2nd MAC cycle -> `out_valid` = 0 and `in_ready` = 1 after release. A following vector gives the correct result with no residue from the aborted one.
